// File: rtl/m_7seg_pkg.sv
// Shared 7-segment symbol table: code constants, segment patterns (active-low g..a)
// and the scan-decoder FSM state type. The display encoder uses the same table.
package m_7seg_pkg;

  // Symbol codes beyond the decimal digits 0-9
  localparam logic [3:0] CODE_PLUS  = 4'ha;
  localparam logic [3:0] CODE_MINUS = 4'hb;
  localparam logic [3:0] CODE_MUL   = 4'hc;
  localparam logic [3:0] CODE_DIV   = 4'hd;
  localparam logic [3:0] CODE_BLANK = 4'he;
  localparam logic [3:0] CODE_EQ    = 4'hf;

  // Segment patterns on seg[6:0] = g..a, active-low
  localparam logic [6:0] SEG_0     = 7'b1000000;
  localparam logic [6:0] SEG_1     = 7'b1111001;
  localparam logic [6:0] SEG_2     = 7'b0100100;
  localparam logic [6:0] SEG_3     = 7'b0110000;
  localparam logic [6:0] SEG_4     = 7'b0011001;
  localparam logic [6:0] SEG_5     = 7'b0010010;
  localparam logic [6:0] SEG_6     = 7'b0000010;
  localparam logic [6:0] SEG_7     = 7'b1111000;
  localparam logic [6:0] SEG_8     = 7'b0000000;
  localparam logic [6:0] SEG_9     = 7'b0011000;
  localparam logic [6:0] SEG_PLUS  = 7'b0111001;
  localparam logic [6:0] SEG_MINUS = 7'b0111111;
  localparam logic [6:0] SEG_MUL   = 7'b0001001;
  localparam logic [6:0] SEG_DIV   = 7'b0101101;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;
  localparam logic [6:0] SEG_EQ    = 7'b0110111;

  // Per-digit stability tracker states
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETTLE = 2'd1,
    ST_HELD   = 2'd2
  } scan_state_e;

endpackage

// File: rtl/m_7seg_pattern_dec.sv
// Combinational segment-pattern decoder: seg[6:0] -> {valid, code}.
// Unknown patterns report valid=0 and a blank code.
module m_7seg_pattern_dec
  import m_7seg_pkg::*;
(
  input  logic [6:0] seg,
  output logic       valid,
  output logic [3:0] code
);

  // Table lookup of the 16 known symbols
  always_comb begin
    valid = 1'b1;
    code  = CODE_BLANK;
    case (seg)
      SEG_0:     code = 4'h0;
      SEG_1:     code = 4'h1;
      SEG_2:     code = 4'h2;
      SEG_3:     code = 4'h3;
      SEG_4:     code = 4'h4;
      SEG_5:     code = 4'h5;
      SEG_6:     code = 4'h6;
      SEG_7:     code = 4'h7;
      SEG_8:     code = 4'h8;
      SEG_9:     code = 4'h9;
      SEG_PLUS:  code = CODE_PLUS;
      SEG_MINUS: code = CODE_MINUS;
      SEG_MUL:   code = CODE_MUL;
      SEG_DIV:   code = CODE_DIV;
      SEG_BLANK: code = CODE_BLANK;
      SEG_EQ:    code = CODE_EQ;
      default: begin
        valid = 1'b0;
        code  = CODE_BLANK;
      end
    endcase
  end

endmodule

// File: rtl/m_7seg_scan_decoder.sv
// Read-back decoder for a multiplexed active-low 7-segment bus. Each scanned digit
// must be stable for STABLE_CYC+1 samples before it is committed; a frame pulse
// fires once every digit has been committed, and unknown patterns raise a sticky error.
module m_7seg_scan_decoder
  import m_7seg_pkg::*;
#(
  parameter int NDIG       = 8,
  parameter int STABLE_CYC = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [7:0]        seg_in,
  input  logic [NDIG-1:0]   dig_sel_n,
  input  logic              err_clr,
  output logic [4*NDIG-1:0] digits_o,
  output logic [NDIG-1:0]   dp_o,
  output logic              frame_valid,
  output logic              err,
  output logic [2:0]        err_digit
);

  localparam logic [7:0]      STABLE_MAX = 8'(STABLE_CYC);
  localparam logic [NDIG-1:0] MASK_NONE  = {NDIG{1'b0}};
  localparam logic [NDIG-1:0] MASK_FULL  = {NDIG{1'b1}};
  localparam logic [NDIG-1:0] SEL_LSB    = {{(NDIG-1){1'b0}}, 1'b1};

  // Input sample and the previous sample used for change detection
  logic [7:0]        seg_r;
  logic [NDIG-1:0]   sel_r;
  logic [7:0]        prev_seg_r;
  logic [NDIG-1:0]   prev_sel_r;

  scan_state_e       state_r, state_nxt_s;
  logic [7:0]        cnt_r, cnt_nxt_s;

  logic [4*NDIG-1:0] digits_r;
  logic [NDIG-1:0]   dp_r;
  logic [NDIG-1:0]   mask_r;
  logic              frame_valid_r;
  logic              err_r;
  logic [2:0]        err_digit_r;

  logic [NDIG-1:0]   sel_act_s;
  logic              sel_valid_s;
  logic [2:0]        sel_idx_s;
  logic              changed_s;
  logic              commit_s;
  logic              commit_ok_s;
  logic              commit_bad_s;
  logic [NDIG-1:0]   commit_bits_s;
  logic              dec_valid_s;
  logic [3:0]        dec_code_s;

  m_7seg_pattern_dec u_dec (
    .seg   (seg_r[6:0]),
    .valid (dec_valid_s),
    .code  (dec_code_s)
  );

  // Sample the bus once; every decision below works on this registered copy
  always_ff @(posedge clk) begin
    if (rst) begin
      seg_r      <= 8'hff;
      sel_r      <= MASK_FULL;
      prev_seg_r <= 8'hff;
      prev_sel_r <= MASK_FULL;
    end else begin
      seg_r      <= seg_in;
      sel_r      <= dig_sel_n;
      prev_seg_r <= seg_r;
      prev_sel_r <= sel_r;
    end
  end

  // A sample is usable only when exactly one digit enable is low
  assign sel_act_s   = ~sel_r;
  assign sel_valid_s = (sel_act_s != MASK_NONE) &&
                       ((sel_act_s & (sel_act_s - SEL_LSB)) == MASK_NONE);
  assign changed_s   = (seg_r != prev_seg_r) || (sel_r != prev_sel_r);

  // Index of the active digit; only meaningful while the select is one-hot
  always_comb begin
    sel_idx_s = 3'd0;
    for (int i = 0; i < NDIG; i++) begin
      sel_idx_s = sel_idx_s | (sel_act_s[i] ? 3'(i) : 3'd0);
    end
  end

  // Stability FSM state and counter registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= ST_IDLE;
      cnt_r   <= 8'd0;
    end else begin
      state_r <= state_nxt_s;
      cnt_r   <= cnt_nxt_s;
    end
  end

  // Next-state: any change restarts counting; a commit happens once per stable run
  always_comb begin
    state_nxt_s = state_r;
    cnt_nxt_s   = cnt_r;
    commit_s    = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (sel_valid_s) begin
          state_nxt_s = ST_SETTLE;
          cnt_nxt_s   = 8'd1;
        end else begin
          state_nxt_s = ST_IDLE;
          cnt_nxt_s   = 8'd0;
        end
      end
      ST_SETTLE: begin
        if (changed_s) begin
          state_nxt_s = sel_valid_s ? ST_SETTLE : ST_IDLE;
          cnt_nxt_s   = sel_valid_s ? 8'd1 : 8'd0;
        end else if (cnt_r >= STABLE_MAX) begin
          commit_s    = 1'b1;
          state_nxt_s = ST_HELD;
        end else begin
          cnt_nxt_s   = cnt_r + 8'd1;
        end
      end
      ST_HELD: begin
        if (changed_s) begin
          state_nxt_s = sel_valid_s ? ST_SETTLE : ST_IDLE;
          cnt_nxt_s   = sel_valid_s ? 8'd1 : 8'd0;
        end else begin
          state_nxt_s = ST_HELD;
        end
      end
      default: begin
        state_nxt_s = ST_IDLE;
        cnt_nxt_s   = 8'd0;
      end
    endcase
  end

  assign commit_ok_s   = commit_s & dec_valid_s;
  assign commit_bad_s  = commit_s & ~dec_valid_s;
  assign commit_bits_s = {NDIG{commit_ok_s}} & sel_act_s;

  // Output registers: digit values, frame mask/pulse and sticky error
  always_ff @(posedge clk) begin
    if (rst) begin
      digits_r      <= {NDIG{CODE_BLANK}};
      dp_r          <= MASK_NONE;
      mask_r        <= MASK_NONE;
      frame_valid_r <= 1'b0;
      err_r         <= 1'b0;
      err_digit_r   <= 3'd0;
    end else begin
      for (int i = 0; i < NDIG; i++) begin
        if (commit_bits_s[i]) begin
          digits_r[4*i +: 4] <= dec_code_s;
          dp_r[i]            <= ~seg_r[7];
        end
      end
      // The pulse cycle restarts the mask but still keeps a commit landing in it
      mask_r        <= frame_valid_r ? commit_bits_s : (mask_r | commit_bits_s);
      frame_valid_r <= ~frame_valid_r & ((mask_r | commit_bits_s) == MASK_FULL);
      // A new error takes priority over a simultaneous clear
      if (commit_bad_s) begin
        err_r       <= 1'b1;
        err_digit_r <= sel_idx_s;
      end else if (err_clr) begin
        err_r       <= 1'b0;
        err_digit_r <= 3'd0;
      end else begin
        err_r       <= err_r;
        err_digit_r <= err_digit_r;
      end
    end
  end

  assign digits_o    = digits_r;
  assign dp_o        = dp_r;
  assign frame_valid = frame_valid_r;
  assign err         = err_r;
  assign err_digit   = err_digit_r;

endmodule

// File: tb/tb_m_7seg_scan_decoder.sv
// Bench for m_7seg_scan_decoder: directed scenarios plus random scanning, all
// outputs compared every cycle against a run-length based reference model.
module tb_m_7seg_scan_decoder;

  localparam int NDIG       = 8;
  localparam int STABLE_CYC = 4;

  logic              clk = 1'b0;
  logic              rst;
  logic [7:0]        seg_in;
  logic [NDIG-1:0]   dig_sel_n;
  logic              err_clr;
  logic [4*NDIG-1:0] digits_o;
  logic [NDIG-1:0]   dp_o;
  logic              frame_valid;
  logic              err;
  logic [2:0]        err_digit;

  int n_checks = 0;
  int n_pass   = 0;
  int fv_cnt   = 0;
  bit chk_en   = 1'b0;

  // Reference model state
  logic [3:0]        m_dig [NDIG];
  logic [NDIG-1:0]   m_dp;
  logic [NDIG-1:0]   m_mask;
  logic              m_fv;
  logic              m_err;
  logic [2:0]        m_errd;
  logic [15:0]       last_sample;
  bit                has_prev;
  int                run_len;

  m_7seg_scan_decoder #(.NDIG(NDIG), .STABLE_CYC(STABLE_CYC)) dut (
    .clk         (clk),
    .rst         (rst),
    .seg_in      (seg_in),
    .dig_sel_n   (dig_sel_n),
    .err_clr     (err_clr),
    .digits_o    (digits_o),
    .dp_o        (dp_o),
    .frame_valid (frame_valid),
    .err         (err),
    .err_digit   (err_digit)
  );

  always #5 clk = ~clk;

  function automatic logic [6:0] pat(input int c);
    case (c)
      0:  pat = 7'b1000000;
      1:  pat = 7'b1111001;
      2:  pat = 7'b0100100;
      3:  pat = 7'b0110000;
      4:  pat = 7'b0011001;
      5:  pat = 7'b0010010;
      6:  pat = 7'b0000010;
      7:  pat = 7'b1111000;
      8:  pat = 7'b0000000;
      9:  pat = 7'b0011000;
      10: pat = 7'b0111001;
      11: pat = 7'b0111111;
      12: pat = 7'b0001001;
      13: pat = 7'b0101101;
      14: pat = 7'b1111111;
      15: pat = 7'b0110111;
      default: pat = 7'b1111111;
    endcase
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
  endtask

  // One clock edge of the model: a digit commits when its sample has been seen
  // unchanged on STABLE_CYC+1 consecutive edges with exactly one select low.
  task automatic model_step();
    logic [NDIG-1:0] act;
    logic [15:0]     cur;
    int              idx;
    int              code;
    bit              hit;
    bit              commit;
    bit              old_fv;
    if (rst) begin
      for (int i = 0; i < NDIG; i++) m_dig[i] = 4'he;
      m_dp = '0; m_mask = '0; m_fv = 1'b0; m_err = 1'b0; m_errd = 3'd0;
      run_len = 0; has_prev = 1'b0; last_sample = 16'hffff;
    end else begin
      if (frame_valid === 1'b1) fv_cnt++;
      act    = ~last_sample[NDIG-1:0];
      commit = has_prev && (run_len == STABLE_CYC + 1) && ($countones(act) == 1);
      old_fv = m_fv;
      hit    = 1'b1;
      if (old_fv) m_mask = '0;
      if (commit) begin
        idx = 0;
        for (int i = 0; i < NDIG; i++) if (act[i]) idx = i;
        hit  = 1'b0;
        code = 0;
        for (int k = 0; k < 16; k++) begin
          if (pat(k) == last_sample[14:8]) begin
            hit  = 1'b1;
            code = k;
          end
        end
        if (hit) begin
          m_dig[idx]  = 4'(code);
          m_dp[idx]   = ~last_sample[15];
          m_mask[idx] = 1'b1;
        end else begin
          m_err  = 1'b1;
          m_errd = 3'(idx);
        end
      end
      if (err_clr && !(commit && !hit)) begin
        m_err  = 1'b0;
        m_errd = 3'd0;
      end
      m_fv = !old_fv && (m_mask == {NDIG{1'b1}});
      cur  = {seg_in, dig_sel_n};
      if (has_prev && cur == last_sample) begin
        if (run_len < 1000) run_len++;
      end else begin
        run_len = 1;
      end
      last_sample = cur;
      has_prev    = 1'b1;
    end
  endtask

  initial forever begin
    @(posedge clk);
    model_step();
  end

  // Per-cycle comparison of every output against the model
  initial forever begin
    logic [31:0] exp_vec;
    @(negedge clk);
    if (chk_en) begin
      for (int i = 0; i < NDIG; i++) exp_vec[4*i +: 4] = m_dig[i];
      check("digits_o", digits_o, exp_vec);
      check("dp_o", 32'(dp_o), 32'(m_dp));
      check("frame_valid", 32'(frame_valid), 32'(m_fv));
      check("err", 32'(err), 32'(m_err));
      check("err_digit", 32'(err_digit), 32'(m_errd));
    end
  end

  task automatic drive(input logic [NDIG-1:0] sel, input logic [7:0] seg, input int n);
    dig_sel_n = sel;
    seg_in    = seg;
    repeat (n) @(negedge clk);
  endtask

  task automatic show(input int d, input int code, input bit dp, input int n);
    logic [NDIG-1:0] one;
    one = 8'b1 << d;
    drive(~one, {~dp, pat(code)}, n);
  endtask

  initial begin
    int codes1 [8];
    int d, c, n;
    logic [NDIG-1:0] sel;
    logic [NDIG-1:0] one;
    logic [7:0] seg;
    codes1 = '{1, 2, 10, 3, 15, 14, 9, 11};
    rst = 1'b1; err_clr = 1'b0; seg_in = 8'hff; dig_sel_n = '1;
    @(negedge clk);
    @(negedge clk);
    chk_en = 1'b1;
    check("reset_digits", digits_o, 32'heeeeeeee);
    check("reset_fv", 32'(frame_valid), 32'd0);
    rst = 1'b0;
    drive('1, 8'hff, 3);

    // 1: full frame 1,2,+,3,=,blank,9,-
    for (int i = 0; i < 8; i++) show(i, codes1[i], 1'b0, 10);
    drive('1, 8'hff, 3);
    check("t1_digits", digits_o, 32'hb9ef3a21);
    check("t1_dp", 32'(dp_o), 32'd0);
    check("t1_pulses", 32'(fv_cnt), 32'd1);

    // 2: unknown pattern on digit 2
    drive(8'b11111011, 8'hd5, 10);
    check("t2_err", 32'(err), 32'd1);
    check("t2_err_digit", 32'(err_digit), 32'd2);
    check("t2_digit2", 32'(digits_o[11:8]), 32'ha);
    err_clr = 1'b1;
    drive('1, 8'hff, 1);
    err_clr = 1'b0;
    check("t2_err_clr", 32'(err), 32'd0);
    check("t2_pulses", 32'(fv_cnt), 32'd1);

    // 3: glitches prevent commit; final stable run commits exactly at t+5
    show(0, 5, 1'b0, 3);
    show(0, 6, 1'b0, 1);
    show(0, 5, 1'b0, 3);
    show(0, 6, 1'b0, 1);
    check("t3_no_commit", 32'(digits_o[3:0]), 32'h1);
    show(0, 5, 1'b0, 5);
    check("t3_before_t5", 32'(digits_o[3:0]), 32'h1);
    show(0, 5, 1'b0, 1);
    check("t3_at_t5", 32'(digits_o[3:0]), 32'h5);
    show(0, 5, 1'b0, 4);

    // 4: blanking gap and double select hold everything
    drive('1, {1'b1, pat(8)}, 20);
    drive(8'b11111100, {1'b1, pat(8)}, 20);
    check("t4_digits", digits_o, 32'hb9ef3a25);
    check("t4_pulses", 32'(fv_cnt), 32'd1);

    // 5: decimal point on digit 5 showing 4
    show(5, 4, 1'b1, 10);
    check("t5_digits", digits_o, 32'hb94f3a25);
    check("t5_dp", 32'(dp_o), 32'h20);

    // 6: reset mid-frame discards the partial frame
    for (int i = 0; i < 5; i++) show(i, 9 - i, 1'b0, 10);
    rst = 1'b1;
    drive('1, 8'hff, 2);
    check("t6_rst_digits", digits_o, 32'heeeeeeee);
    check("t6_rst_dp", 32'(dp_o), 32'd0);
    check("t6_rst_err", 32'(err), 32'd0);
    rst = 1'b0;
    for (int i = 0; i < 8; i++) show(i, i, 1'b0, 10);
    drive('1, 8'hff, 3);
    check("t6_digits", digits_o, 32'h76543210);
    check("t6_pulses", 32'(fv_cnt), 32'd2);

    // Random scanning around the stability boundary, checked by the model
    for (int it = 0; it < 500; it++) begin
      d   = $urandom_range(0, NDIG - 1);
      c   = $urandom_range(0, 15);
      n   = $urandom_range(1, 9);
      one = 8'b1 << d;
      sel = ~one;
      if ($urandom_range(0, 9) == 0) sel = ($urandom_range(0, 1) == 0) ? 8'hff : ~(one | 8'h01 | 8'h80);
      seg = {1'($urandom_range(0, 1)), pat(c)};
      if ($urandom_range(0, 9) == 0) seg[6:0] = 7'($urandom_range(0, 127));
      for (int k = 0; k < n; k++) begin
        err_clr = ($urandom_range(0, 15) == 0);
        drive(sel, seg, 1);
      end
    end
    err_clr = 1'b0;
    drive('1, 8'hff, 4);
    chk_en = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
